// File: rtl/sram_pkg.sv
// Shared types and helpers for the banked dual-port SRAM.
package sram_pkg;

  // Requester identity; also the encoding of the round-robin pointer.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  localparam int NUM_PORTS = 2;

  // Number of address bits consumed by bank selection (0 for a single bank).
  function automatic int bank_bits(input int num_banks);
    return (num_banks <= 1) ? 0 : $clog2(num_banks);
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port bank: byte-enable writes, one-cycle registered read, no reset on the array.
module sram_bank #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int ROW_W      = 8,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ROW_W-1:0]      i_row,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [BE_WIDTH-1:0]   i_be,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-masked write or registered read of the addressed row.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (i_be[b]) begin
            r_mem[i_row][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_row];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_banked_dp.sv
// Dual-port banked SRAM: round-robin arbitration on same-bank collisions,
// per-port read-latency pipeline and a held read-data output.
module sram_banked_dp
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_BANKS    = 4,
  parameter int READ_LATENCY = 1,
  localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  input  logic [BE_WIDTH-1:0]   a_req_be,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  input  logic [BE_WIDTH-1:0]   b_req_be,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata
);

  localparam int BANK_BITS  = bank_bits(NUM_BANKS);
  localparam int BANK_IDX_W = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_BITS   = ADDR_WIDTH - BANK_BITS;
  localparam int ROW_W      = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int BANK_DEPTH = 1 << ROW_BITS;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } mem_req_t;

  genvar gi;

  mem_req_t              w_req        [NUM_PORTS];
  logic                  w_valid      [NUM_PORTS];
  logic                  w_ready      [NUM_PORTS];
  logic                  w_fire       [NUM_PORTS];
  logic [BANK_IDX_W-1:0] w_bank       [NUM_PORTS];
  logic [ROW_W-1:0]      w_row        [NUM_PORTS];
  logic                  w_rsp_valid  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_rsp_rdata  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];
  logic                  w_same_bank;
  logic                  w_conflict;
  port_e                 r_ptr;

  // Gather the two flat port bundles into indexable arrays.
  assign w_valid[0] = a_req_valid;
  assign w_valid[1] = b_req_valid;
  assign w_req[0]   = {a_req_we, a_req_addr, a_req_wdata, a_req_be};
  assign w_req[1]   = {b_req_we, b_req_addr, b_req_wdata, b_req_be};

  // Low-order interleave: bank from the bottom address bits, row from the rest.
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_dec
    if (BANK_BITS == 0) begin : g_one_bank
      assign w_bank[gi] = '0;
      assign w_row[gi]  = w_req[gi].addr[ROW_W-1:0];
    end else begin : g_multi_bank
      assign w_bank[gi] = w_req[gi].addr[BANK_BITS-1:0];
      if (ROW_BITS > 0) begin : g_rows
        assign w_row[gi] = w_req[gi].addr[ADDR_WIDTH-1:BANK_BITS];
      end else begin : g_no_rows
        assign w_row[gi] = '0;
      end
    end
  end

  // Ready only drops when the other port targets the same bank and holds priority,
  // so a port's ready never looks at its own valid.
  assign w_same_bank = (w_bank[0] == w_bank[1]);
  assign w_conflict  = w_valid[0] && w_valid[1] && w_same_bank;
  assign w_ready[0]  = !(w_valid[1] && w_same_bank && (r_ptr == PORT_B));
  assign w_ready[1]  = !(w_valid[0] && w_same_bank && (r_ptr == PORT_A));
  assign w_fire[0]   = w_valid[0] && w_ready[0];
  assign w_fire[1]   = w_valid[1] && w_ready[1];

  // Round-robin pointer hands priority to the loser after every conflict cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PORT_A;
    end else if (w_conflict) begin
      r_ptr <= (r_ptr == PORT_A) ? PORT_B : PORT_A;
    end
  end

  // Bank request mux: at most one port can fire into a given bank per cycle.
  for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic                  w_sel_a;
    logic                  w_sel_b;
    logic                  w_we;
    logic [ROW_W-1:0]      w_row_sel;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BE_WIDTH-1:0]   w_be;

    assign w_sel_a   = w_fire[0] && (w_bank[0] == BANK_IDX_W'(gi));
    assign w_sel_b   = w_fire[1] && (w_bank[1] == BANK_IDX_W'(gi));
    assign w_we      = w_sel_a ? w_req[0].we    : w_req[1].we;
    assign w_row_sel = w_sel_a ? w_row[0]       : w_row[1];
    assign w_wdata   = w_sel_a ? w_req[0].wdata : w_req[1].wdata;
    assign w_be      = w_sel_a ? w_req[0].be    : w_req[1].be;

    sram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BANK_DEPTH),
      .ROW_W      (ROW_W)
    ) u_bank (
      .clk     (clk),
      .i_en    (w_sel_a || w_sel_b),
      .i_we    (w_we),
      .i_row   (w_row_sel),
      .i_wdata (w_wdata),
      .i_be    (w_be),
      .o_rdata (w_bank_rdata[gi])
    );
  end

  // Per-port return path: bank tag, extra latency stages and held output data.
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic                  r_v0;
    logic [BANK_IDX_W-1:0] r_tag0;
    logic [DATA_WIDTH-1:0] w_d0;
    logic                  w_fin_v;
    logic [DATA_WIDTH-1:0] w_fin_d;
    logic [DATA_WIDTH-1:0] r_hold;

    assign w_d0 = w_bank_rdata[r_tag0];

    // Track which bank will present this port's read data on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v0   <= 1'b0;
        r_tag0 <= '0;
      end else begin
        r_v0   <= w_fire[gi] && !w_req[gi].we;
        r_tag0 <= w_bank[gi];
      end
    end

    if (READ_LATENCY > 1) begin : g_pipe
      logic                  r_pv [1:READ_LATENCY-1];
      logic [DATA_WIDTH-1:0] r_pd [1:READ_LATENCY-1];

      // Delay line carrying valid and data; every stage advances every cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 1; k < READ_LATENCY; k++) begin
            r_pv[k] <= 1'b0;
            r_pd[k] <= '0;
          end
        end else begin
          r_pv[1] <= r_v0;
          r_pd[1] <= w_d0;
          for (int k = 2; k < READ_LATENCY; k++) begin
            r_pv[k] <= r_pv[k-1];
            r_pd[k] <= r_pd[k-1];
          end
        end
      end

      assign w_fin_v = r_pv[READ_LATENCY-1];
      assign w_fin_d = r_pd[READ_LATENCY-1];
    end else begin : g_direct
      assign w_fin_v = r_v0;
      assign w_fin_d = w_d0;
    end

    // Remember the last delivered word so rdata is stable between responses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold <= '0;
      end else if (w_fin_v) begin
        r_hold <= w_fin_d;
      end
    end

    assign w_rsp_valid[gi] = w_fin_v;
    assign w_rsp_rdata[gi] = w_fin_v ? w_fin_d : r_hold;
  end

  assign a_req_ready = w_ready[0];
  assign b_req_ready = w_ready[1];
  assign a_rsp_valid = w_rsp_valid[0];
  assign b_rsp_valid = w_rsp_valid[1];
  assign a_rsp_rdata = w_rsp_rdata[0];
  assign b_rsp_rdata = w_rsp_rdata[1];

endmodule

// File: tb/tb_sram_banked_dp.sv
// Randomised and directed bench for sram_banked_dp against a behavioural memory model.
module tb_sram_banked_dp;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int NB = 4;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req_valid = 1'b0, b_req_valid = 1'b0;
  logic          a_req_ready, b_req_ready;
  logic          a_req_we = 1'b0, b_req_we = 1'b0;
  logic [AW-1:0] a_req_addr = '0, b_req_addr = '0;
  logic [DW-1:0] a_req_wdata = '0, b_req_wdata = '0;
  logic [7:0]    a_req_be = '0, b_req_be = '0;
  logic          a_rsp_valid, b_rsp_valid;
  logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;

  sram_banked_dp #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .NUM_BANKS    (NB),
    .READ_LATENCY (RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_req_we    (a_req_we),
    .a_req_addr  (a_req_addr),
    .a_req_wdata (a_req_wdata),
    .a_req_be    (a_req_be),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_rdata (a_rsp_rdata),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_req_we    (b_req_we),
    .b_req_addr  (b_req_addr),
    .b_req_wdata (b_req_wdata),
    .b_req_be    (b_req_be),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_rdata (b_rsp_rdata)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int          due;
    logic [63:0] data;
  } rsp_t;

  logic [63:0] mem [1024];
  rsp_t        q [2][$];
  logic [63:0] last_rd [2];
  int          prio;          // 0 = A holds priority, 1 = B
  int          cyc;
  logic        acc_a, acc_b, obs_ar;
  int          n_vec, n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_write(input logic [AW-1:0] addr, input logic [63:0] wd, input logic [7:0] be);
    for (int b = 0; b < 8; b++)
      if (be[b]) mem[addr][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  task automatic chk_rsp(input int p, input logic v, input logic [63:0] d);
    string nm;
    nm = (p == 0) ? "a" : "b";
    if (q[p].size() > 0 && q[p][0].due == cyc) begin
      chk({nm, "_rsp_valid"}, {63'd0, v}, 64'd1);
      chk({nm, "_rsp_rdata"}, d, q[p][0].data);
      last_rd[p] = q[p][0].data;
      void'(q[p].pop_front());
    end else begin
      chk({nm, "_rsp_valid"}, {63'd0, v}, 64'd0);
      chk({nm, "_rsp_hold"}, d, last_rd[p]);
    end
  endtask

  // One clock cycle: check DUT against the model mid-cycle, then advance the model.
  task automatic step();
    logic same, exp_ar, exp_br;
    @(negedge clk);
    if (!rst_n) begin
      q[0].delete(); q[1].delete();
      last_rd[0] = '0; last_rd[1] = '0;
      prio = 0;
    end
    same   = ((a_req_addr % NB) == (b_req_addr % NB));
    exp_ar = !(b_req_valid && same && prio == 1);
    exp_br = !(a_req_valid && same && prio == 0);
    obs_ar = a_req_ready;
    chk("a_req_ready", {63'd0, a_req_ready}, {63'd0, exp_ar});
    chk("b_req_ready", {63'd0, b_req_ready}, {63'd0, exp_br});
    chk_rsp(0, a_rsp_valid, a_rsp_rdata);
    chk_rsp(1, b_rsp_valid, b_rsp_rdata);
    acc_a = rst_n && a_req_valid && exp_ar;
    acc_b = rst_n && b_req_valid && exp_br;
    if (acc_a && !a_req_we) q[0].push_back('{cyc + RL, mem[a_req_addr]});
    if (acc_b && !b_req_we) q[1].push_back('{cyc + RL, mem[b_req_addr]});
    if (acc_a && a_req_we) model_write(a_req_addr, a_req_wdata, a_req_be);
    if (acc_b && b_req_we) model_write(b_req_addr, b_req_wdata, b_req_be);
    if (acc_a) $display("txn A %s addr=%0d wdata=%h be=%h", a_req_we ? "wr" : "rd", a_req_addr, a_req_wdata, a_req_be);
    if (acc_b) $display("txn B %s addr=%0d wdata=%h be=%h", b_req_we ? "wr" : "rd", b_req_addr, b_req_wdata, b_req_be);
    if (rst_n && a_req_valid && b_req_valid && same) prio = 1 - prio;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic new_req(output logic v, output logic we, output logic [AW-1:0] addr,
                         output logic [63:0] wd, output logic [7:0] be);
    v    = ($urandom_range(0, 3) != 0);
    we   = ($urandom_range(0, 9) < 4);
    addr = AW'($urandom_range(0, 63));
    wd   = {$urandom, $urandom};
    be   = 8'($urandom);
  endtask

  initial begin
    logic [3:0] pat;
    n_vec = 0; n_err = 0; cyc = 0; prio = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    acc_a = 1'b0; acc_b = 1'b0; obs_ar = 1'b0;

    // Power-on reset: outputs must be zero while held.
    #1;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Fill the low 64 words through port A.
    for (int i = 0; i < 64; i++) begin
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = AW'(i);
      a_req_wdata = {$urandom, $urandom}; a_req_be = 8'hFF;
      step();
    end

    // Byte-enable merge on address 5.
    a_req_addr = 10'd5; a_req_we = 1'b1;
    a_req_wdata = 64'h1122334455667788; a_req_be = 8'hFF; step();
    a_req_wdata = 64'hAAAAAAAAAAAAAAAA; a_req_be = 8'h0F; step();
    a_req_we = 1'b0; step();
    idle(RL + 1);
    chk("be_merge", a_rsp_rdata, 64'h11223344AAAAAAAA);

    // Parallel, different banks: addr 4 (bank 0) and addr 7 (bank 3).
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 10'd4;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 10'd7;
    step();
    idle(RL + 1);

    // Streaming: eight back-to-back reads on A.
    for (int i = 0; i < 8; i++) begin
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = AW'(i);
      step();
    end
    idle(RL + 1);

    // Cross-port coherence: B writes 9, A reads 9 the next cycle.
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 10'd9;
    b_req_wdata = 64'hDEAD; b_req_be = 8'hFF;
    step();
    b_req_valid = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 10'd9;
    step();
    idle(RL + 1);
    chk("xport_rdata", a_rsp_rdata, 64'hDEAD);

    // Reset mid-read: the accepted read must never respond.
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 10'd3;
    step();
    a_req_valid = 1'b0; rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_ready", {63'd0, a_req_ready}, 64'd1);
    idle(RL + 1);

    // Conflict on bank 2 with pointer at A: acceptances alternate A, B, A, B.
    pat = '0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 10'd2;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 10'd6;
    for (int i = 0; i < 4; i++) begin
      step();
      pat = {pat[2:0], obs_ar};
    end
    chk("conflict_pattern", {60'd0, pat}, 64'hA);
    idle(RL + 1);

    // Random traffic honouring the hold-while-stalled rule.
    for (int i = 0; i < 600; i++) begin
      if (!(a_req_valid && !acc_a))
        new_req(a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_be);
      if (!(b_req_valid && !acc_b))
        new_req(b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_be);
      step();
    end
    idle(RL + 2);
    chk("a_drain", 64'(q[0].size()), 64'd0);
    chk("b_drain", 64'(q[1].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_banked_dp.md
Name: sram_banked_dp

Overview:
Dual-port, multi-bank SRAM model with byte-write masks, valid/ready request handshakes and a parameterised read-latency pipeline. Successor to the single-port behavioural SRAM. Two independent requesters (e.g. octree traversal engine and node-update engine) share NUM_BANKS low-order-interleaved banks. Same-bank collisions are resolved by round-robin arbitration.

Parameters:
DATA_WIDTH, 64, word width in bits; must be a multiple of 8
ADDR_WIDTH, 10, word-address width; total depth = 2**ADDR_WIDTH
NUM_BANKS, 4, bank count; power of two, 1..16, must be <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from accepted read to rsp_valid; legal 1..3
BE_WIDTH, DATA_WIDTH/8, derived localparam; bytes per word

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_req_valid  in  1  port A request present
a_req_ready  out  1  port A request accepted this cycle if valid
a_req_we  in  1  1 = write, 0 = read
a_req_addr  in  ADDR_WIDTH  word address
a_req_wdata  in  DATA_WIDTH  write data
a_req_be  in  BE_WIDTH  byte enables; bit i covers byte i
a_rsp_valid  out  1  read data valid
a_rsp_rdata  out  DATA_WIDTH  read data
b_* (the same eight signals for port B)

Behaviour:
- Reset: asserting rst_n clears all rsp_valid/rsp_rdata to 0, clears the latency pipelines and sets the round-robin pointer to A. Memory contents are not reset.
- Reset mid-operation: in-flight reads are dropped with no response. Writes already accepted before reset assertion stay in the array.
- Bank mapping: bank = addr[log2(NUM_BANKS)-1:0], row = remaining upper bits. With NUM_BANKS = 1 all accesses target bank 0.
- Handshake: a request is accepted when valid && ready at the rising edge. The requester must hold its payload stable while valid && !ready.
- Ready is combinational. x_req_ready = 1 unless the other port is valid to the same bank and holds priority. Ready never depends on the port's own valid.
- Arbitration: conflict = both valid && same bank. The priority holder wins. After every conflict cycle the pointer moves to the loser. The pointer is unchanged on non-conflict cycles, so there is no starvation: the loser wins within one cycle.
- Different banks: both ports are accepted in the same cycle.
- Writes: for each i with be[i]=1, byte i of the addressed word is updated. A write with be = 0 is accepted but changes nothing. Writes produce no response.
- Reads: rsp_valid pulses for one cycle exactly READ_LATENCY cycles after acceptance. Responses return in order per port.
- rsp_rdata holds its last value when rsp_valid = 0.
- Read after write (same or other port) in a later cycle returns the new data. Same-cycle same-bank access is impossible because arbitration serialises it.
- Back-to-back reads sustain one response per cycle per port. The pipeline is fully pipelined with no bubbles.
- Simulation X on valid is not required to be handled.

Decomposition:
- Package sram_pkg holds:
  - mem_req_t struct (we, addr, wdata, be), parameterised via localparams or a typedef inside the module
  - PORT_A/PORT_B constants
  - clog2-based BANK_BITS helper function
- Sub-module sram_bank is a single-port, byte-enable, no-reset array with 1-cycle registered read. It is instantiated NUM_BANKS times.
- The top level contains:
  - the arbiter and bank mux/demux
  - per-port READ_LATENCY-1 extra pipeline stages carrying valid and rdata
  - a per-port bank-select tag for the return mux

Test Plan:
- Reset mid-read: issue an A read, assert rst_n on the next cycle → a_rsp_valid stays 0. Afterwards a_req_ready = 1 and the pointer is at A.
- Byte enables: A writes addr 5 = 0x1122334455667788 with be 0xFF, then writes 0xAAAA… with be 0x0F. A reads addr 5 → 0x11223344AAAAAAAA after READ_LATENCY cycles.
- Parallel access, no conflict: with NUM_BANKS = 4, A reads addr 4 (bank 0) while B reads addr 7 (bank 3) in the same cycle → both ready = 1, and both rsp_valid fire together READ_LATENCY cycles later.
- Conflict arbitration: A and B both hold valid to bank 2 (addr 2, addr 6) for 4 cycles.
  - Acceptances alternate A, B, A, B.
  - The loser's ready is 0 on each conflict cycle.
- Streaming: with READ_LATENCY = 3, A issues 8 back-to-back reads to addr 0..7 → 8 consecutive rsp_valid cycles starting 3 cycles after the first, with data in order.
- Cross-port coherence: B writes addr 9 = 0xDEAD with full be; A reads addr 9 the next cycle → returns 0xDEAD.
